// File: rtl/ucie_ctl_sb_pkg.sv
// Shared message layout and helpers for the queued sideband link.
package ucie_ctl_sb_pkg;

  // 64-bit sideband message: decode, adv-cap value, reserved zeros, even parity on top
  localparam int MSG_W   = 64;
  localparam int DEC_LSB = 0;
  localparam int DEC_W   = 5;
  localparam int VAL_LSB = 5;
  localparam int VAL_W   = 32;
  localparam int PAY_W   = DEC_W + VAL_W;
  localparam int PAR_BIT = MSG_W - 1;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Expand a {value, decode} payload into a full message with even parity in the top bit
  function automatic logic [MSG_W-1:0] sb_pack(input logic [PAY_W-1:0] pay);
    logic [MSG_W-1:0] m;
    m            = '0;
    m[PAY_W-1:0] = pay;
    m[PAR_BIT]   = ^m[PAR_BIT-1:0];
    return m;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_fifo.sv
// Small synchronous FIFO with a combinational head view; pop frees a slot for a same-cycle push.
module ucie_ctl_sb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage write port; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_queued_link.sv
// Queued sideband endpoint: credit-gated TX serialiser and checked, buffered RX deserialiser.
module ucie_ctl_sb_queued_link
  import ucie_ctl_sb_pkg::*;
#(
  parameter int          NC       = 8,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4,
  parameter int          TX_CRD   = 4,
  parameter logic [31:0] SUP_MASK = 32'hFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_lp_sb,
  input  logic [4:0]        i_rdi_lp_sb_decode,
  input  logic [31:0]       i_rdi_lp_adv_cap_value,
  output logic              o_pl_sb_busy,
  input  logic              i_rdi_pl_cfg_crd,
  output logic              o_rdi_lp_cfg_vld,
  output logic [NC-1:0]     o_rdi_lp_cfg,
  input  logic              i_pl_cfg_vld,
  input  logic [NC-1:0]     i_received_data,
  output logic              o_cfg_crd,
  output logic              o_valid_pl_sb,
  input  logic              i_rx_pop,
  output logic [4:0]        o_rdi_pl_sb_decode,
  output logic [31:0]       o_rdi_pl_adv_cap_value,
  output logic              o_sb_parity_error,
  output logic              o_sb_unsupported_message,
  output logic              o_rx_overflow
);

  localparam int BEATS = MSG_W / NC;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(TX_CRD + 1);
  localparam int PW    = $clog2(RX_DEPTH + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  // ---------------- TX path ----------------
  logic             tx_full, tx_empty, tx_push, tx_launch, tx_can_launch;
  logic [PAY_W-1:0] tx_head;
  logic [MSG_W-1:0] tx_msg, tx_shift;
  logic [CW-1:0]    tx_crd;
  logic [BCW-1:0]   tx_beat;
  tx_state_t        tx_state;

  assign tx_push      = i_valid_lp_sb && !tx_full;
  assign o_pl_sb_busy = tx_full;
  assign tx_msg       = sb_pack(tx_head);

  // A credit arriving this cycle can fund a launch immediately
  assign tx_can_launch = !tx_empty && ((tx_crd != '0) || i_rdi_pl_cfg_crd);
  assign tx_launch     = tx_can_launch &&
                         ((tx_state == TX_IDLE) || (tx_beat == LAST_BEAT));

  ucie_ctl_sb_fifo #(.WIDTH(PAY_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst(i_rst),
    .push(tx_push), .push_data({i_rdi_lp_adv_cap_value, i_rdi_lp_sb_decode}),
    .pop(tx_launch), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  // Credit counter: returns saturate at TX_CRD, a return and a debit together cancel
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_crd <= CW'(TX_CRD);
    end else if (i_rdi_pl_cfg_crd && !tx_launch && (tx_crd != CW'(TX_CRD))) begin
      tx_crd <= tx_crd + 1'b1;
    end else if (!i_rdi_pl_cfg_crd && tx_launch) begin
      tx_crd <= tx_crd - 1'b1;
    end
  end

  // TX FSM: load shifter on launch, then stream BEATS gapless beats from registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state         <= TX_IDLE;
      tx_beat          <= '0;
      tx_shift         <= '0;
      o_rdi_lp_cfg_vld <= 1'b0;
      o_rdi_lp_cfg     <= '0;
    end else if (tx_launch) begin
      tx_state         <= TX_SEND;
      tx_beat          <= '0;
      o_rdi_lp_cfg_vld <= 1'b1;
      o_rdi_lp_cfg     <= tx_msg[NC-1:0];
      tx_shift         <= tx_msg >> NC;
    end else if (tx_state == TX_SEND) begin
      if (tx_beat == LAST_BEAT) begin
        tx_state         <= TX_IDLE;
        tx_beat          <= '0;
        o_rdi_lp_cfg_vld <= 1'b0;
        o_rdi_lp_cfg     <= '0;
      end else begin
        tx_beat      <= tx_beat + 1'b1;
        o_rdi_lp_cfg <= tx_shift[NC-1:0];
        tx_shift     <= tx_shift >> NC;
      end
    end
  end

  // ---------------- RX path ----------------
  logic             rx_last, rx_par_err, rx_unsup, rx_ovf, rx_push, rx_drop, rx_pop;
  logic             rx_full, rx_empty;
  logic [PAY_W-1:0] rx_head;
  logic [MSG_W-1:0] rx_buf, rx_msg;
  logic [BCW-1:0]   rx_beat;
  logic [PW-1:0]    crd_pend;
  logic [PW+1:0]    crd_total;

  assign rx_last = i_pl_cfg_vld && (rx_beat == LAST_BEAT);

  // Full message view on the last beat: stored beats plus the beat on the wire
  always_comb begin
    rx_msg = rx_buf;
    rx_msg[(BEATS-1)*NC +: NC] = i_received_data;
  end

  assign rx_pop     = i_rx_pop && !rx_empty;
  assign rx_par_err = rx_last && (^rx_msg);
  assign rx_unsup   = rx_last && !rx_par_err && !SUP_MASK[rx_msg[DEC_LSB +: DEC_W]];
  assign rx_ovf     = rx_last && !rx_par_err && !rx_unsup && rx_full && !rx_pop;
  assign rx_push    = rx_last && !rx_par_err && !rx_unsup && !rx_ovf;
  assign rx_drop    = rx_par_err || rx_unsup || rx_ovf;

  ucie_ctl_sb_fifo #(.WIDTH(PAY_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(i_clk), .rst(i_rst),
    .push(rx_push), .push_data(rx_msg[PAY_W-1:0]),
    .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  assign o_valid_pl_sb          = !rx_empty;
  assign o_rdi_pl_sb_decode     = rx_empty ? '0 : rx_head[DEC_LSB +: DEC_W];
  assign o_rdi_pl_adv_cap_value = rx_empty ? '0 : rx_head[VAL_LSB +: VAL_W];

  // Deserialiser: collect beats, wrap the counter after the last one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_beat <= '0;
      rx_buf  <= '0;
    end else if (i_pl_cfg_vld) begin
      rx_buf[rx_beat*NC +: NC] <= i_received_data;
      rx_beat <= rx_last ? '0 : rx_beat + 1'b1;
    end
  end

  // Credit return: a freed slot or a dropped message each owe one pulse; extras wait in crd_pend
  assign crd_total = (PW+2)'(crd_pend) + (PW+2)'(rx_pop) + (PW+2)'(rx_drop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crd_pend  <= '0;
      o_cfg_crd <= 1'b0;
    end else if (crd_total != '0) begin
      crd_pend  <= PW'(crd_total - 1'b1);
      o_cfg_crd <= 1'b1;
    end else begin
      o_cfg_crd <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sb_parity_error        <= 1'b0;
      o_sb_unsupported_message <= 1'b0;
      o_rx_overflow            <= 1'b0;
    end else begin
      if (rx_par_err) o_sb_parity_error        <= 1'b1;
      if (rx_unsup)   o_sb_unsupported_message <= 1'b1;
      if (rx_ovf)     o_rx_overflow            <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ucie_ctl_sb_queued_link.sv
// Scoreboard bench for the queued sideband link (NC=16, TX_CRD=2, depth 4 both ways).
module tb_ucie_ctl_sb_queued_link;

  localparam int NC    = 16;
  localparam int BEATS = 64 / NC;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid_lp_sb = 1'b0;
  logic [4:0]  i_rdi_lp_sb_decode = '0;
  logic [31:0] i_rdi_lp_adv_cap_value = '0;
  logic        o_pl_sb_busy;
  logic        i_rdi_pl_cfg_crd = 1'b0;
  logic        o_rdi_lp_cfg_vld;
  logic [NC-1:0] o_rdi_lp_cfg;
  logic        i_pl_cfg_vld = 1'b0;
  logic [NC-1:0] i_received_data = '0;
  logic        o_cfg_crd;
  logic        o_valid_pl_sb;
  logic        i_rx_pop = 1'b0;
  logic [4:0]  o_rdi_pl_sb_decode;
  logic [31:0] o_rdi_pl_adv_cap_value;
  logic        o_sb_parity_error;
  logic        o_sb_unsupported_message;
  logic        o_rx_overflow;

  always #5 clk = ~clk;

  ucie_ctl_sb_queued_link #(
    .NC(NC), .TX_DEPTH(4), .RX_DEPTH(4), .TX_CRD(2), .SUP_MASK(32'hFFFF)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_valid_lp_sb(i_valid_lp_sb), .i_rdi_lp_sb_decode(i_rdi_lp_sb_decode),
    .i_rdi_lp_adv_cap_value(i_rdi_lp_adv_cap_value), .o_pl_sb_busy(o_pl_sb_busy),
    .i_rdi_pl_cfg_crd(i_rdi_pl_cfg_crd), .o_rdi_lp_cfg_vld(o_rdi_lp_cfg_vld),
    .o_rdi_lp_cfg(o_rdi_lp_cfg), .i_pl_cfg_vld(i_pl_cfg_vld),
    .i_received_data(i_received_data), .o_cfg_crd(o_cfg_crd),
    .o_valid_pl_sb(o_valid_pl_sb), .i_rx_pop(i_rx_pop),
    .o_rdi_pl_sb_decode(o_rdi_pl_sb_decode), .o_rdi_pl_adv_cap_value(o_rdi_pl_adv_cap_value),
    .o_sb_parity_error(o_sb_parity_error), .o_sb_unsupported_message(o_sb_unsupported_message),
    .o_rx_overflow(o_rx_overflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tx_beats = 0;
  logic [NC-1:0] tx_q[$];
  logic [36:0]   rx_q[$];
  logic [NC-1:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference message builder: decode, value, zero pad, even parity in bit 63
  function automatic logic [63:0] mk_msg(input logic [4:0] dec, input logic [31:0] val);
    logic [63:0] m;
    m        = '0;
    m[4:0]   = dec;
    m[36:5]  = val;
    m[63]    = ^m[62:0];
    return m;
  endfunction

  // TX scoreboard: every valid beat must match the next expected beat
  always @(negedge clk) begin
    if (o_rdi_lp_cfg_vld) begin
      if (tx_q.size() == 0) begin
        chk("tx_unexpected_beat", {63'd0, o_rdi_lp_cfg_vld}, 64'd0);
      end else begin
        mon_exp = tx_q.pop_front();
        $display("tx beat %0h (exp %0h)", o_rdi_lp_cfg, mon_exp);
        chk("tx_beat", {48'd0, o_rdi_lp_cfg}, {48'd0, mon_exp});
      end
      tx_beats++;
    end
  end

  task automatic push_tx(input logic [4:0] dec, input logic [31:0] val);
    logic [63:0] m;
    m = mk_msg(dec, val);
    @(negedge clk);
    i_valid_lp_sb = 1'b1; i_rdi_lp_sb_decode = dec; i_rdi_lp_adv_cap_value = val;
    for (int k = 0; k < BEATS; k++) tx_q.push_back(m[k*NC +: NC]);
    @(negedge clk);
    i_valid_lp_sb = 1'b0;
  endtask

  task automatic crd_pulse();
    @(negedge clk); i_rdi_pl_cfg_crd = 1'b1;
    @(negedge clk); i_rdi_pl_cfg_crd = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int w = 0;
    while (tx_q.size() != 0 && w < bound) begin @(negedge clk); w++; end
    chk(tag, 64'(tx_q.size()), 64'd0);
  endtask

  task automatic chk_head();
    logic [36:0] e;
    chk("rx_head_valid", {63'd0, o_valid_pl_sb}, 64'd1);
    if (rx_q.size() == 0) begin
      chk("rx_scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = rx_q.pop_front();
      $display("rx msg dec=%0d val=%0h (exp dec=%0d val=%0h)",
               o_rdi_pl_sb_decode, o_rdi_pl_adv_cap_value, e[4:0], e[36:5]);
      chk("rx_decode", {59'd0, o_rdi_pl_sb_decode}, {59'd0, e[4:0]});
      chk("rx_value", {32'd0, o_rdi_pl_adv_cap_value}, {32'd0, e[36:5]});
    end
  endtask

  task automatic send_rx(input logic [63:0] m, input bit pop_last);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      i_pl_cfg_vld = 1'b1; i_received_data = m[k*NC +: NC];
      if (pop_last && k == BEATS-1) begin chk_head(); i_rx_pop = 1'b1; end
    end
    @(negedge clk);
    i_pl_cfg_vld = 1'b0; i_received_data = '0; i_rx_pop = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk);
    chk_head();
    i_rx_pop = 1'b1;
    @(negedge clk);
    i_rx_pop = 1'b0;
    chk("rx_pop_crd", {63'd0, o_cfg_crd}, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"},   {63'd0, o_rdi_lp_cfg_vld}, 64'd0);
    chk({tag, "_cfg"},   {48'd0, o_rdi_lp_cfg}, 64'd0);
    chk({tag, "_busy"},  {63'd0, o_pl_sb_busy}, 64'd0);
    chk({tag, "_crd"},   {63'd0, o_cfg_crd}, 64'd0);
    chk({tag, "_valid"}, {63'd0, o_valid_pl_sb}, 64'd0);
    chk({tag, "_dec"},   {59'd0, o_rdi_pl_sb_decode}, 64'd0);
    chk({tag, "_val"},   {32'd0, o_rdi_pl_adv_cap_value}, 64'd0);
    chk({tag, "_flags"}, {61'd0, o_sb_parity_error, o_sb_unsupported_message, o_rx_overflow}, 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    int b0;
    int w;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    i_rst = 1'b0;

    // Single message: first beat two cycles after the push edge, beats per format
    push_tx(5'd5, 32'hDEADBEEF);
    chk("tx_lat_vld_low", {63'd0, o_rdi_lp_cfg_vld}, 64'd0);
    @(negedge clk);
    chk("tx_lat_vld_high", {63'd0, o_rdi_lp_cfg_vld}, 64'd1);
    chk("tx_first_beat", {48'd0, o_rdi_lp_cfg}, 64'hDDE5);
    wait_drain("tx_single_drain", 50);

    // Credit limit: restore to 2 credits, four messages, only two go out
    crd_pulse();
    b0 = tx_beats;
    push_tx(5'd1, 32'h11111111);
    push_tx(5'd2, 32'h22222222);
    push_tx(5'd3, 32'h33333333);
    push_tx(5'd4, 32'h44444444);
    repeat (40) @(negedge clk);
    chk("tx_credit_limit_beats", 64'(tx_beats - b0), 64'd8);
    chk("tx_credit_limit_vld", {63'd0, o_rdi_lp_cfg_vld}, 64'd0);
    chk("tx_credit_limit_pending", 64'(tx_q.size()), 64'd8);

    // Fill the TX FIFO, then pushes while busy must be ignored
    push_tx(5'd6, $urandom);
    push_tx(5'd7, $urandom);
    chk("tx_busy_full", {63'd0, o_pl_sb_busy}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_valid_lp_sb = 1'b1; i_rdi_lp_sb_decode = 5'd31; i_rdi_lp_adv_cap_value = 32'hFFFFFFFF;
    end
    @(negedge clk);
    i_valid_lp_sb = 1'b0;
    chk("tx_busy_hold", {63'd0, o_pl_sb_busy}, 64'd1);

    // Credit with no banked credits: next message starts the following cycle
    crd_pulse();
    chk("tx_crd_restart_vld", {63'd0, o_rdi_lp_cfg_vld}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      crd_pulse();
    end
    wait_drain("tx_fifo_drain", 100);

    // Saturation: three returns at TX_CRD=2 leave two credits
    repeat (3) crd_pulse();
    b0 = tx_beats;
    push_tx(5'd8, $urandom);
    push_tx(5'd9, $urandom);
    push_tx(5'd10, $urandom);
    repeat (40) @(negedge clk);
    chk("tx_sat_beats", 64'(tx_beats - b0), 64'd8);
    chk("tx_sat_pending", 64'(tx_q.size()), 64'd4);
    crd_pulse();
    wait_drain("tx_sat_drain", 50);

    // RX good message, then pop and credit return
    m = mk_msg(5'd3, 32'h12345678);
    rx_q.push_back(m[36:0]);
    send_rx(m, 1'b0);
    chk("rx_good_valid", {63'd0, o_valid_pl_sb}, 64'd1);
    chk("rx_good_no_crd", {63'd0, o_cfg_crd}, 64'd0);
    pop_rx();
    @(negedge clk);
    chk("rx_pop_crd_pulse_end", {63'd0, o_cfg_crd}, 64'd0);
    chk("rx_empty_after_pop", {63'd0, o_valid_pl_sb}, 64'd0);

    // Parity error: bit 10 flipped
    m = mk_msg(5'd7, 32'hA5A50F0F);
    m[10] = ~m[10];
    send_rx(m, 1'b0);
    chk("rx_par_flag", {63'd0, o_sb_parity_error}, 64'd1);
    chk("rx_par_crd", {63'd0, o_cfg_crd}, 64'd1);
    chk("rx_par_valid", {63'd0, o_valid_pl_sb}, 64'd0);
    @(negedge clk);
    chk("rx_par_crd_end", {63'd0, o_cfg_crd}, 64'd0);
    chk("rx_par_no_unsup", {63'd0, o_sb_unsupported_message}, 64'd0);

    // Unsupported decode (bit 20 clear in SUP_MASK)
    send_rx(mk_msg(5'd20, 32'h00C0FFEE), 1'b0);
    chk("rx_unsup_flag", {63'd0, o_sb_unsupported_message}, 64'd1);
    chk("rx_unsup_crd", {63'd0, o_cfg_crd}, 64'd1);
    chk("rx_unsup_valid", {63'd0, o_valid_pl_sb}, 64'd0);

    // Fill RX FIFO with four good messages
    for (int i = 0; i < 4; i++) begin
      m = mk_msg(5'(i + 1), $urandom);
      rx_q.push_back(m[36:0]);
      send_rx(m, 1'b0);
    end
    chk("rx_full_no_ovf", {63'd0, o_rx_overflow}, 64'd0);

    // Pop and push together while full: accepted, no overflow
    m = mk_msg(5'd11, $urandom);
    rx_q.push_back(m[36:0]);
    send_rx(m, 1'b1);
    chk("rx_poppush_no_ovf", {63'd0, o_rx_overflow}, 64'd0);
    chk("rx_poppush_crd", {63'd0, o_cfg_crd}, 64'd1);

    // Fifth message into a full FIFO with no pop: dropped, overflow flagged
    send_rx(mk_msg(5'd12, 32'hBADBAD00), 1'b0);
    chk("rx_ovf_flag", {63'd0, o_rx_overflow}, 64'd1);
    chk("rx_ovf_crd", {63'd0, o_cfg_crd}, 64'd1);

    // Drop and pop in the same cycle: two consecutive credit pulses
    m = mk_msg(5'd13, 32'h0F0F0F0F);
    m[0] = ~m[0];
    send_rx(m, 1'b1);
    chk("rx_dual_crd_1", {63'd0, o_cfg_crd}, 64'd1);
    @(negedge clk);
    chk("rx_dual_crd_2", {63'd0, o_cfg_crd}, 64'd1);
    @(negedge clk);
    chk("rx_dual_crd_end", {63'd0, o_cfg_crd}, 64'd0);
    for (int i = 0; i < 3; i++) pop_rx();
    @(negedge clk);
    chk("rx_drained", {63'd0, o_valid_pl_sb}, 64'd0);
    chk("rx_scoreboard_left", 64'(rx_q.size()), 64'd0);

    // Reset during beat 2 of a TX message and of an RX message
    crd_pulse();
    push_tx(5'd9, 32'hCAFEF00D);
    w = 0;
    while (!o_rdi_lp_cfg_vld && w < 20) begin @(negedge clk); w++; end
    chk("tx_start_bound", {63'd0, o_rdi_lp_cfg_vld}, 64'd1);
    m = mk_msg(5'd2, 32'h55AA55AA);
    i_pl_cfg_vld = 1'b1; i_received_data = m[15:0];
    @(negedge clk);
    i_received_data = m[31:16];
    @(negedge clk);
    i_rst = 1'b1; i_pl_cfg_vld = 1'b0; i_received_data = '0;
    @(negedge clk);
    chk_all_zero("midrst");
    i_rst = 1'b0;
    tx_q.delete();

    // After reset: credits back to TX_CRD, fresh transfers in both directions
    b0 = tx_beats;
    push_tx(5'd14, $urandom);
    push_tx(5'd15, $urandom);
    push_tx(5'd16, $urandom);
    repeat (40) @(negedge clk);
    chk("post_rst_tx_beats", 64'(tx_beats - b0), 64'd8);
    chk("post_rst_tx_pending", 64'(tx_q.size()), 64'd4);
    crd_pulse();
    wait_drain("post_rst_tx_drain", 50);
    m = mk_msg(5'd6, 32'h600DF00D);
    rx_q.push_back(m[36:0]);
    send_rx(m, 1'b0);
    chk("post_rst_rx_no_par", {63'd0, o_sb_parity_error}, 64'd0);
    pop_rx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
